// File: rtl/score_draw_engine.sv
// Draws DIGITS BCD glyphs from a row-addressed font ROM into a pixel frame buffer.
// Optional: define SCORE_BLANK_LEADING_ZEROS_EN to draw leading zero digits blank.
module score_draw_engine #(
    parameter int         DIGITS   = 4,
    parameter int         X0       = 8,
    parameter int         Y0       = 8,
    parameter int         SCREEN_W = 320,
    parameter logic [7:0] FG       = 8'hFF,
    parameter logic [7:0] BG       = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        draw_score_start,
    input  logic [15:0] score,
    output logic        draw_score_done,
    output logic        busy,
    output logic [6:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [7:0]  fb_data,
    input  logic        fb_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

    state_t      r_state;
    logic [15:0] r_score;
    logic [1:0]  r_digit;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_glyph;

    state_t      w_state_n;
    logic [15:0] w_score_n;
    logic [1:0]  w_digit_n;
    logic [2:0]  w_row_n;
    logic [2:0]  w_col_n;
    logic [7:0]  w_glyph_n;
    logic [3:0]  w_nib;
    logic [3:0]  w_fnib;
    logic        w_blank;
    logic [6:0]  w_font_n;
    logic [16:0] w_addr_n;
    logic [7:0]  w_data_n;

    // Digit 0 is the most significant nibble actually in use.
    function automatic logic [3:0] nib_of(
        input logic [15:0] s,
        input logic [1:0]  d
    );
        logic [3:0] v;
        v = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (k == DIGITS - 1 - int'(d)) v = s[4*k +: 4];
        end
        return v;
    endfunction

    function automatic logic lead_zero(
        input logic [15:0] s,
        input logic [1:0]  d
    );
        logic z;
        z = (int'(d) != DIGITS - 1);
        for (int k = 0; k < 4; k++) begin
            if (k <= int'(d) && nib_of(s, 2'(k)) != 4'd0) z = 1'b0;
        end
        return z;
    endfunction

    assign w_nib = nib_of(r_score, r_digit);

`ifdef SCORE_BLANK_LEADING_ZEROS_EN
    assign w_blank = (w_nib > 4'd9) || lead_zero(r_score, r_digit);
`else
    assign w_blank = (w_nib > 4'd9);
`endif

    always_comb begin
        w_state_n = r_state;
        w_score_n = r_score;
        w_digit_n = r_digit;
        w_row_n   = r_row;
        w_col_n   = r_col;
        w_glyph_n = r_glyph;
        unique case (r_state)
            S_IDLE: begin
                if (draw_score_start) begin
                    w_state_n = S_FETCH;
                    w_score_n = score;
                    w_digit_n = 2'd0;
                    w_row_n   = 3'd0;
                    w_col_n   = 3'd0;
                end
            end
            S_FETCH: begin
                w_state_n = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                w_state_n = S_WRITE;
                w_glyph_n = w_blank ? 8'h00 : font_data;
                w_col_n   = 3'd0;
            end
            S_WRITE: begin
                if (fb_ack) begin
                    if (r_col == 3'd7) begin
                        if (r_row == 3'd7 && r_digit == LAST_DIGIT) begin
                            w_state_n = S_DONE;
                        end else begin
                            w_state_n = S_FETCH;
                            w_row_n   = r_row + 3'd1;
                            if (r_row == 3'd7) w_digit_n = r_digit + 2'd1;
                        end
                    end else begin
                        w_col_n = r_col + 3'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next-cycle counters.
    assign w_fnib   = nib_of(w_score_n, w_digit_n);
    assign w_font_n = (w_fnib > 4'd9) ? 7'd0 : {w_fnib, w_row_n};
    assign w_data_n = w_glyph_n[~w_col_n] ? FG : BG;
    assign w_addr_n = 17'((Y0 + int'(w_row_n)) * SCREEN_W + X0
                          + int'(w_digit_n) * 8 + int'(w_col_n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_score         <= 16'd0;
            r_digit         <= 2'd0;
            r_row           <= 3'd0;
            r_col           <= 3'd0;
            r_glyph         <= 8'd0;
            busy            <= 1'b0;
            fb_we           <= 1'b0;
            draw_score_done <= 1'b0;
            fb_addr         <= 17'd0;
            fb_data         <= 8'd0;
            font_addr       <= 7'd0;
        end else begin
            r_state         <= w_state_n;
            r_score         <= w_score_n;
            r_digit         <= w_digit_n;
            r_row           <= w_row_n;
            r_col           <= w_col_n;
            r_glyph         <= w_glyph_n;
            busy            <= (w_state_n != S_IDLE);
            fb_we           <= (w_state_n == S_WRITE);
            draw_score_done <= (w_state_n == S_DONE);
            fb_addr         <= w_addr_n;
            fb_data         <= w_data_n;
            font_addr       <= w_font_n;
        end
    end

endmodule

// File: tb/tb_score_draw_engine.sv
// Directed bench for score_draw_engine: timing, addresses, pixels, stall,
// ignored restart, blanking and mid-frame reset.
module tb_score_draw_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] score = 16'd0;
    logic        done;
    logic        busy;
    logic [6:0]  fa;
    logic [7:0]  fd = 8'd0;
    logic        fb_we;
    logic [16:0] fba;
    logic [7:0]  fbd;
    logic        fb_ack = 1'b1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    int          run_id = 0;
    int          seen_id = 0;
    logic [15:0] cur = 16'd0;
    bit          stall_en = 1'b0;
    int          stall_left;
    int          nwr, first_cyc, done_cnt, done_cyc;
    int          addr_bad, pix_bad, fa_bad, hold_bad;
    logic [16:0] first_addr, last_addr, ha;
    logic [7:0]  hd;
    int          t0;

    score_draw_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .draw_score_start (start),
        .score            (score),
        .draw_score_done  (done),
        .busy             (busy),
        .font_addr        (fa),
        .font_data        (fd),
        .fb_we            (fb_we),
        .fb_addr          (fba),
        .fb_data          (fbd),
        .fb_ack           (fb_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [6:0] a);
        if (a >= 7'd80) return 8'h00;
        return 8'(int'(a) * 37 + 11) ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fd  <= rom(fa);
    end

    function automatic logic [3:0] nib(input logic [15:0] s, input int d);
        return s[4*(3-d) +: 4];
    endfunction

    function automatic logic [7:0] exp_pix(input logic [15:0] s, input int k);
        int d, r, c;
        logic [3:0] v;
        logic [7:0] g;
        logic blank;
        d = k / 64;
        r = (k / 8) % 8;
        c = k % 8;
        v = nib(s, d);
        blank = (v > 4'd9);
`ifdef SCORE_BLANK_LEADING_ZEROS_EN
        if (d < 3) begin
            logic z;
            z = 1'b1;
            for (int j = 0; j <= d; j++) if (nib(s, j) != 4'd0) z = 1'b0;
            if (z) blank = 1'b1;
        end
`endif
        g = blank ? 8'h00 : rom(7'(int'(v) * 8 + r));
        return g[7-c] ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [16:0] exp_addr(input int k);
        int d, r, c;
        d = k / 64;
        r = (k / 8) % 8;
        c = k % 8;
        return 17'((8 + r) * 320 + 8 + d * 8 + c);
    endfunction

    function automatic logic [6:0] exp_fa(input logic [15:0] s, input int k);
        logic [3:0] v;
        v = nib(s, k / 8);
        if (v > 4'd9) return 7'd0;
        return 7'(int'(v) * 8 + k % 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observer: drives fb_ack and scores every accepted write.
    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id    = run_id;
            stall_left = 5;
            nwr        = 0;
            first_cyc  = -1;
            done_cnt   = 0;
            done_cyc   = -1;
            addr_bad   = 0;
            pix_bad    = 0;
            fa_bad     = 0;
            hold_bad   = 0;
            first_addr = '0;
            last_addr  = '0;
        end
        if (rst_n) begin
            if (stall_en && fb_we && nwr == 3 && stall_left > 0) begin
                fb_ack = 1'b0;
                if (stall_left == 5) begin
                    ha = fba;
                    hd = fbd;
                end else if (fba !== ha || fbd !== hd) begin
                    hold_bad++;
                end
                stall_left--;
            end else begin
                fb_ack = 1'b1;
            end
            if (fb_we && fb_ack) begin
                if (nwr == 0) begin
                    first_cyc  = cyc;
                    first_addr = fba;
                end
                last_addr = fba;
                if (nwr < 256) begin
                    if (fba !== exp_addr(nwr)) addr_bad++;
                    if (fbd !== exp_pix(cur, nwr)) pix_bad++;
                end
                nwr++;
            end
            if (busy && !fb_we && !done && nwr / 8 < 32) begin
                if (fa !== exp_fa(cur, nwr / 8)) fa_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic kick(input logic [15:0] s);
        @(negedge clk);
        cur   = s;
        run_id++;
        start = 1'b1;
        score = s;
        @(negedge clk);
        t0    = cyc;
        start = 1'b0;
        score = 16'hFFFF;
    endtask

    task automatic finish_run(input string tag, input int lat);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_latency"}, done_cyc - t0 + 1, lat);
        check({tag, "_writes"}, nwr, 256);
        check({tag, "_addr_bad"}, addr_bad, 0);
        check({tag, "_pix_bad"}, pix_bad, 0);
        check({tag, "_fa_bad"}, fa_bad, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_we", fb_we, 0);
        check("rst_done", done, 0);
        check("rst_fa", fa, 0);
        check("rst_fba", fba, 0);
        check("rst_fbd", fbd, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal frame
        stall_en = 1'b0;
        kick(16'h1234);
        check("n_busy_c1", busy, 1);
        finish_run("n", 321);
        check("n_first_we", first_cyc - t0 + 1, 3);
        check("n_first_addr", first_addr, 2568);
        check("n_last_addr", last_addr, 4839);

        // Five-cycle stall on pixel 3
        stall_en = 1'b1;
        kick(16'h1234);
        finish_run("s", 326);
        check("s_hold_bad", hold_bad, 0);
        check("s_stalled", stall_left, 0);
        stall_en = 1'b0;

        // Restart attempt while busy
        kick(16'h1234);
        repeat (48) @(negedge clk);
        start = 1'b1;
        score = 16'h9999;
        @(negedge clk);
        start = 1'b0;
        finish_run("ig", 321);

        // Zero digits and an out-of-range nibble
        kick(16'h00A7);
        finish_run("bl", 321);

        // Mid-frame reset, then a clean restart
        kick(16'h1234);
        repeat (98) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_we", fb_we, 0);
        check("mr_busy", busy, 0);
        check("mr_fa", fa, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mr_no_done", done_cnt, 0);
        kick(16'h0001);
        finish_run("rs", 321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_draw_engine.md
SCORE_DRAW_ENGINE -- requirements
Module: score_draw_engine

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits drawn (1-4).
REQ-002 Parameter X0, default 8: pixel column of the leftmost digit's left edge.
REQ-003 Parameter Y0, default 8: pixel row of the digits' top edge.
REQ-004 Parameter SCREEN_W, default 320: frame-buffer line stride in pixels.
REQ-005 Parameter FG, default 8'hFF: colour of glyph pixels whose font bit is 1.
REQ-006 Parameter BG, default 8'h00: colour of glyph pixels whose font bit is 0.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 draw_score_start  in  1  one-cycle start pulse from the SPU controller.
REQ-010 score  in  16  four BCD nibbles; [15:12] is the most significant digit.
REQ-011 draw_score_done  out  1  one-cycle completion pulse to the SPU controller.
REQ-012 busy  out  1  high from the cycle after start is accepted through the done cycle.
REQ-013 font_addr  out  7  glyph ROM address = digit_value*8 + row.
REQ-014 font_data  in  8  glyph row, valid one cycle after font_addr; bit7 is the leftmost pixel.
REQ-015 fb_we  out  1  frame-buffer write request.
REQ-016 fb_addr  out  17  frame-buffer pixel address.
REQ-017 fb_data  out  8  pixel colour.
REQ-018 fb_ack  in  1  frame-buffer write accept; ignored while fb_we is low.

Function
REQ-019 States: IDLE, FETCH, WAIT_ROM, WRITE, DONE; registered outputs.
- IDLE->FETCH on draw_score_start.
- FETCH->WAIT_ROM unconditionally.
- WAIT_ROM->WRITE unconditionally, capturing font_data.
- WRITE->FETCH after the 8th pixel acked, unless last row of last digit, then ->DONE.
- DONE->IDLE unconditionally.
REQ-020 The score is latched on the accepted start cycle; later score changes do not affect the frame in progress.
REQ-021 draw_score_start while busy is ignored; no restart, no queuing.
REQ-022 Draw order: digit 0 (MSD of the DIGITS used, i.e. nibble DIGITS-1) first; within a digit rows 0-7; within a row columns 0-7.
REQ-023 fb_addr = (Y0+row)*SCREEN_W + X0 + digit*8 + col, computed at full 17-bit width with no truncation of intermediates.
REQ-024 fb_data = FG if font bit (7-col) is 1, else BG.
REQ-025 fb_we, fb_addr and fb_data hold stable until the cycle in which fb_ack=1 is sampled; the next pixel is presented the following cycle.
REQ-026 A BCD nibble greater than 9 draws an all-BG glyph, and font_addr for it is driven to 0.
REQ-027 draw_score_done is high for exactly one cycle (the DONE state) after the final write is acked; it is never asserted otherwise.
REQ-028 With fb_ack tied high: first fb_we in the 3rd cycle after the start edge, 10 cycles per glyph row, and done high 321 cycles after the start edge (DIGITS=4).

Reset
REQ-029 rst_n low forces IDLE asynchronously; busy, fb_we, draw_score_done, fb_addr, fb_data and font_addr are 0, and latched score and counters are 0.
REQ-030 Reset mid-operation aborts the frame with no done pulse; the first start after release is accepted normally.

Configuration
REQ-031 Macro SCORE_BLANK_LEADING_ZEROS_EN:
- Defined: zero digits preceding the first nonzero digit are drawn all-BG; the last digit is always drawn.
- Undefined: all digits are drawn as glyphs.
- Write count and timing are identical in both cases.

Verification
REQ-032 score=16'h1234, fb_ack=1 -> 256 writes; first fb_addr=8*320+8=2568; last fb_addr=15*320+39=4839; done at cycle 321.
REQ-033 fb_ack low for 5 cycles on pixel 3 -> fb_we/fb_addr/fb_data held constant; total completion delayed by exactly 5 cycles.
REQ-034 Second start at cycle 50 with score=16'h9999 -> ignored; the drawn glyphs remain 1,2,3,4; exactly one done pulse.
REQ-035 score=16'h00A7 with macro defined -> digits 0,1,2 all BG (the A nibble also blanks), digit 3 is the '7' glyph; without the macro -> '0','0', blank, '7'.
REQ-036 rst_n pulsed low at cycle 100 -> fb_we=0 immediately and no done pulse; a restart with 16'h0001 completes in 321 cycles.
